div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter W, default 16, operand/result width (W >= 4).
REQ-002 Parameter CW, default $clog2(W), iteration counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request; operands sampled on the same edge.
REQ-006 sgn  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-007 a  input  W  dividend.
REQ-008 b  input  W  divisor.
REQ-009 q  output  W  quotient.
REQ-010 r  output  W  remainder.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 ready  output  1  high while q/r hold a completed result.
REQ-013 dbz  output  1  divide-by-zero flag, valid while ready=1.
REQ-014 ovf  output  1  signed overflow flag (MIN / -1), valid while ready=1.

Function
REQ-015 FSM states: IDLE, RUN, FIX, DONE.
REQ-016 IDLE or DONE with start=1 latches the operands and sgn, clears q/r/flags and ready, sets busy, and goes to RUN; the counter is set to 0.
REQ-017 Start with b=0 sets dbz and goes to FIX, bypassing RUN.
REQ-018 In signed mode, RUN operates on |a| and |b|, and the operand signs are latched at start.
REQ-019 RUN performs one restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor (W+1-bit difference), set quo LSB to NOT the borrow, restore rem on borrow.
REQ-020 RUN lasts exactly W cycles; the counter wraps cleanly at W-1 and then FSM goes to FIX.
REQ-021 FIX, signed mode: negate the quotient if the operand signs differ; give the remainder the dividend's sign; unsigned mode passes values through.
REQ-022 FIX, dbz: q = all ones, r = a (as given).
REQ-023 FIX, signed a = 2^(W-1) with b = -1: q = 2^(W-1), r = 0, ovf = 1.
REQ-024 FIX then goes to DONE: busy=0, ready=1; q/r/flags stay stable until the next accepted start.
REQ-025 Latency for a normal divide is W+2 edges from the start edge to ready high; divide-by-zero takes 2 edges.
REQ-026 start while busy=1 is ignored; the operation in flight is unaffected.
REQ-027 start in DONE is accepted on the same edge (back-to-back); ready drops on that edge.
REQ-028 The invariant a = q*b + r (W-bit, sign-consistent) holds whenever ready=1, dbz=0 and ovf=0.

Reset
REQ-029 clrn low forces, asynchronously: state=IDLE, busy=0, ready=0, q=0, r=0, dbz=0, ovf=0, counter=0, internal operand registers=0.
REQ-030 Reset during RUN or FIX abandons the operation; no ready pulse is produced after release.
REQ-031 The first start after clrn deasserts behaves as from power-up.

Structure
REQ-032 Shared package div_pkg holds the FSM state encodings (2-bit localparams) and the default W.
REQ-033 One sub-module, div_step: combinational, one restoring iteration over W+1 bits, instantiated once and reused each RUN cycle.
REQ-034 Sign handling (abs, negate) lives in div_seq and uses no divider or multiplier operators.

Verification
REQ-035 W=16, sgn=0, a=100, b=7 -> after 18 edges ready=1, q=14, r=2, dbz=0, ovf=0.
REQ-036 W=16, sgn=1, a=-100 (0xFF9C), b=7 -> q=0xFFF2 (-14), r=0xFFFE (-2).
REQ-037 W=16, sgn=1, a=0x8000, b=0xFFFF -> q=0x8000, r=0, ovf=1.
REQ-038 W=16, a=5, b=0 -> ready after 2 edges, q=0xFFFF, r=5, dbz=1.
REQ-039 Start at 100/7, pulse start with 9/3 at cycle 5, then clrn low at cycle 10 -> the second start is ignored; all outputs are 0 during reset; ready never rises before the next start.
REQ-040 Randomised back-to-back starts in DONE, both modes, W=8 and W=32 -> the REQ-028 invariant and the latency in REQ-025 hold for every operation.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the default operand width.
package div_pkg;

   localparam int DIV_W_DEFAULT = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial
// subtract the divisor over W+1 bits, keep or restore the partial remainder.
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_W_DEFAULT
) (
   input  logic [W-1:0] i_rem,
   input  logic [W-1:0] i_quo,
   input  logic [W-1:0] i_div,
   output logic [W-1:0] o_rem,
   output logic [W-1:0] o_quo
);

   logic [W:0] w_part;
   logic [W:0] w_diff;
   logic       w_borrow;

   // Since rem < div on entry, the W+1-bit difference lies in [-div, div-1],
   // so its top bit is exactly the borrow.
   always_comb begin
      w_part   = {i_rem, i_quo[W-1]};
      w_diff   = w_part - {1'b0, i_div};
      w_borrow = w_diff[W];
      o_rem    = w_borrow ? w_part[W-1:0] : w_diff[W-1:0];
      o_quo    = {i_quo[W-2:0], ~w_borrow};
   end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider: one restoring step per cycle over the
// operand magnitudes, followed by a sign-fixup cycle.
module div_seq
   import div_pkg::*;
#(
   parameter int W  = DIV_W_DEFAULT,
   parameter int CW = $clog2(W)
) (
   input  logic         clk,
   input  logic         clrn,
   input  logic         start,
   input  logic         sgn,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] q,
   output logic [W-1:0] r,
   output logic         busy,
   output logic         ready,
   output logic         dbz,
   output logic         ovf
);

   localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(W-1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t        r_state;
   state_t        w_next;
   logic          w_accept;

   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_div;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_q;
   logic [W-1:0]  r_r;
   logic          r_sgn;
   logic          r_sa;
   logic          r_sb;
   logic          r_dbz;
   logic          r_ovf;

   logic          w_a_neg;
   logic          w_b_neg;
   logic [W-1:0]  w_a_abs;
   logic [W-1:0]  w_b_abs;
   logic [W-1:0]  w_rem_nx;
   logic [W-1:0]  w_quo_nx;
   logic          w_min_m1;
   logic [W-1:0]  w_q_fix;
   logic [W-1:0]  w_r_fix;

   function automatic logic [W-1:0] f_neg(input logic [W-1:0] x);
      return ~x + ONE;
   endfunction

   // Operand magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
   always_comb begin
      w_a_neg = sgn & a[W-1];
      w_b_neg = sgn & b[W-1];
      w_a_abs = w_a_neg ? f_neg(a) : a;
      w_b_abs = w_b_neg ? f_neg(b) : b;
   end

   div_step #(.W(W)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_rem_nx),
      .o_quo (w_quo_nx)
   );

   // Final result selection: divide-by-zero, MIN / -1, or sign-corrected magnitudes.
   always_comb begin
      w_min_m1 = r_sgn && (r_a == MIN_VAL) && (r_b == {W{1'b1}});
      w_q_fix  = (r_sa ^ r_sb) ? f_neg(r_quo) : r_quo;
      w_r_fix  = r_sa ? f_neg(r_rem) : r_rem;
      if (r_dbz) begin
         w_q_fix = {W{1'b1}};
         w_r_fix = r_a;
      end else if (w_min_m1) begin
         w_q_fix = MIN_VAL;
         w_r_fix = '0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state and status outputs; a start is only honoured when not busy.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = 1'b0;
      ready    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            ready = (r_state == DONE);
            if (start) begin
               w_accept = 1'b1;
               w_next   = (b == '0) ? FIX : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_cnt == CNT_LAST) w_next = FIX;
         end
         FIX: begin
            busy   = 1'b1;
            w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, iterate in RUN, publish results in FIX.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_div <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_sgn <= 1'b0;
         r_sa  <= 1'b0;
         r_sb  <= 1'b0;
         r_dbz <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_a   <= a;
         r_b   <= b;
         r_div <= w_b_abs;
         r_rem <= '0;
         r_quo <= w_a_abs;
         r_q   <= '0;
         r_r   <= '0;
         r_sgn <= sgn;
         r_sa  <= w_a_neg;
         r_sb  <= w_b_neg;
         r_dbz <= (b == '0);
         r_ovf <= 1'b0;
      end else if (r_state == RUN) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
      end else if (r_state == FIX) begin
         r_q   <= w_q_fix;
         r_r   <= w_r_fix;
         r_ovf <= w_min_m1 & ~r_dbz;
      end
   end

   assign q   = r_q;
   assign r   = r_r;
   assign dbz = r_dbz;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq at W=8, 16 and 32: stimulus pushes expected
// results, a monitor pops and compares on every rising ready.
module tb_div_seq;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      bit          s;
      bit          dbz;
      bit          ovf;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic [2:0]  st = 3'b000;
   logic        sgn_i = 1'b0;
   logic [31:0] a_bus = '0;
   logic [31:0] b_bus = '0;

   wire  [7:0]  q8, r8;
   wire  [15:0] q16, r16;
   wire  [31:0] q32, r32;
   wire  [2:0]  busy_v, rdy_v, dbz_v, ovf_v;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   exp_t sq0[$];
   exp_t sq1[$];
   exp_t sq2[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   div_seq #(.W(8)) u8 (
      .clk(clk), .clrn(clrn), .start(st[0]), .sgn(sgn_i), .a(a_bus[7:0]), .b(b_bus[7:0]),
      .q(q8), .r(r8), .busy(busy_v[0]), .ready(rdy_v[0]), .dbz(dbz_v[0]), .ovf(ovf_v[0]));

   div_seq #(.W(16)) u16 (
      .clk(clk), .clrn(clrn), .start(st[1]), .sgn(sgn_i), .a(a_bus[15:0]), .b(b_bus[15:0]),
      .q(q16), .r(r16), .busy(busy_v[1]), .ready(rdy_v[1]), .dbz(dbz_v[1]), .ovf(ovf_v[1]));

   div_seq #(.W(32)) u32 (
      .clk(clk), .clrn(clrn), .start(st[2]), .sgn(sgn_i), .a(a_bus), .b(b_bus),
      .q(q32), .r(r32), .busy(busy_v[2]), .ready(rdy_v[2]), .dbz(dbz_v[2]), .ovf(ovf_v[2]));

   function automatic int wid(int k);
      return (k == 0) ? 8 : ((k == 1) ? 16 : 32);
   endfunction

   function automatic logic [31:0] outq(int k);
      case (k)
         0:       return {24'b0, q8};
         1:       return {16'b0, q16};
         default: return q32;
      endcase
   endfunction

   function automatic logic [31:0] outr(int k);
      case (k)
         0:       return {24'b0, r8};
         1:       return {16'b0, r16};
         default: return r32;
      endcase
   endfunction

   // Reference: plain integer division on sign-extended values, C-style truncation.
   function automatic exp_t model(int k, bit s, logic [31:0] a, logic [31:0] b);
      exp_t        e;
      int          w;
      logic [63:0] m;
      longint      av, bv, qv, rv;
      w     = wid(k);
      m     = (64'd1 << w) - 64'd1;
      e.a   = a & m[31:0];
      e.b   = b & m[31:0];
      e.s   = s;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.due = 0;
      if (e.b == 32'd0) begin
         e.dbz = 1'b1;
         e.q   = m[31:0];
         e.r   = e.a;
      end else begin
         av = longint'({32'b0, e.a});
         bv = longint'({32'b0, e.b});
         if (s) begin
            if (e.a[w-1]) av = av - (longint'(1) << w);
            if (e.b[w-1]) bv = bv - (longint'(1) << w);
         end
         qv    = av / bv;
         rv    = av % bv;
         e.q   = 32'(qv) & m[31:0];
         e.r   = 32'(rv) & m[31:0];
         e.ovf = s && (e.a == (32'd1 << (w - 1))) && (e.b == m[31:0]);
      end
      return e;
   endfunction

   function automatic void push(int k, exp_t e);
      case (k)
         0:       sq0.push_back(e);
         1:       sq1.push_back(e);
         default: sq2.push_back(e);
      endcase
   endfunction

   function automatic int qsize(int k);
      case (k)
         0:       return sq0.size();
         1:       return sq1.size();
         default: return sq2.size();
      endcase
   endfunction

   function automatic exp_t pop(int k);
      case (k)
         0:       return sq0.pop_front();
         1:       return sq1.pop_front();
         default: return sq2.pop_front();
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every rising ready retires the oldest expectation of that DUT.
   logic [2:0] prev_rdy = 3'b000;
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] m, lhs;
      for (int k = 0; k < 3; k++) begin
         if (rdy_v[k] && !prev_rdy[k]) begin
            if (qsize(k) == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_ready dut%0d: ready rose with no operation pending at cycle %0d", k, cyc);
            end else begin
               e = pop(k);
               chk($sformatf("q_w%0d_%0h_%0h", wid(k), e.a, e.b), outq(k), e.q);
               chk($sformatf("r_w%0d_%0h_%0h", wid(k), e.a, e.b), outr(k), e.r);
               chk($sformatf("dbz_w%0d", wid(k)), {31'b0, dbz_v[k]}, {31'b0, e.dbz});
               chk($sformatf("ovf_w%0d", wid(k)), {31'b0, ovf_v[k]}, {31'b0, e.ovf});
               chk($sformatf("latency_w%0d", wid(k)), cyc, e.due);
               if (!e.dbz && !e.ovf) begin
                  m   = (64'd1 << wid(k)) - 64'd1;
                  lhs = (({32'b0, outq(k)} * {32'b0, e.b}) + {32'b0, outr(k)}) & m;
                  chk($sformatf("invariant_w%0d", wid(k)), lhs[31:0], e.a);
               end
            end
         end
      end
      prev_rdy <= rdy_v;
   end

   // Drive a start at the current negedge and record what must come back.
   task automatic issue(int k, bit s, logic [31:0] a, logic [31:0] b);
      exp_t e;
      e = model(k, s, a, b);
      e.due = cyc + (e.dbz ? 2 : wid(k) + 2);
      st[k] = 1'b1;
      sgn_i = s;
      a_bus = a;
      b_bus = b;
      push(k, e);
      @(negedge clk);
      st[k] = 1'b0;
      chk($sformatf("ready_drops_w%0d", wid(k)), {31'b0, rdy_v[k]}, 32'd0);
      chk($sformatf("busy_set_w%0d", wid(k)), {31'b0, busy_v[k]}, 32'd1);
   endtask

   task automatic wait_ready(int k, int limit);
      int n;
      n = 0;
      while (!rdy_v[k] && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_v[k]) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout_w%0d: ready=0 after %0d cycles, expected 1", wid(k), limit);
      end
   endtask

   task automatic directed(string nm, bit s, logic [31:0] a, logic [31:0] b,
                           logic [31:0] eq, logic [31:0] er, bit edz, bit eov);
      issue(1, s, a, b);
      wait_ready(1, 40);
      chk({nm, "_q"},   {16'b0, q16}, eq);
      chk({nm, "_r"},   {16'b0, r16}, er);
      chk({nm, "_dbz"}, {31'b0, dbz_v[1]}, {31'b0, edz});
      chk({nm, "_ovf"}, {31'b0, ovf_v[1]}, {31'b0, eov});
   endtask

   task automatic run_rand(int k, int n);
      int          w, pat;
      bit          s;
      logic [31:0] a, b;
      w = wid(k);
      for (int i = 0; i < n; i++) begin
         pat = $urandom_range(0, 9);
         s   = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         if (pat == 0) b = 32'd0;
         else if (pat == 1) begin
            s = 1'b1;
            a = 32'd1 << (w - 1);
            b = 32'hFFFF_FFFF;
         end else if (pat == 2) b = 32'($urandom_range(1, 3));
         else if (pat == 3) b = b >> (w / 2);
         issue(k, s, a, b);
         wait_ready(k, w + 10);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_ready_w%0d", wid(k)), {31'b0, rdy_v[k]}, 32'd0);
         chk($sformatf("reset_busy_w%0d", wid(k)),  {31'b0, busy_v[k]}, 32'd0);
         chk($sformatf("reset_q_w%0d", wid(k)),     outq(k), 32'd0);
      end
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);

      directed("u100_7",    1'b0, 32'd100,    32'd7,      32'd14,     32'd2,      1'b0, 1'b0);
      directed("s-100_7",   1'b1, 32'hFF9C,   32'd7,      32'hFFF2,   32'hFFFE,   1'b0, 1'b0);
      directed("s100_-7",   1'b1, 32'd100,    32'hFFF9,   32'hFFF2,   32'd2,      1'b0, 1'b0);
      directed("min_m1",    1'b1, 32'h8000,   32'hFFFF,   32'h8000,   32'd0,      1'b0, 1'b1);
      directed("dbz5",      1'b0, 32'd5,      32'd0,      32'hFFFF,   32'd5,      1'b1, 1'b0);
      directed("u_max_1",   1'b0, 32'hFFFF,   32'd1,      32'hFFFF,   32'd0,      1'b0, 1'b0);
      directed("u_small_big", 1'b0, 32'd3,    32'hFFFF,   32'd0,      32'd3,      1'b0, 1'b0);

      // A start while busy must not disturb the operation in flight.
      issue(1, 1'b0, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      st[1] = 1'b1; a_bus = 32'd9; b_bus = 32'd3;
      @(negedge clk);
      st[1] = 1'b0;
      wait_ready(1, 40);
      chk("ignored_start_q", {16'b0, q16}, 32'd14);
      chk("ignored_start_r", {16'b0, r16}, 32'd2);

      // Reset mid-operation: outputs clear, the pending result never appears.
      issue(1, 1'b0, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      st[1] = 1'b1; a_bus = 32'd9; b_bus = 32'd3;
      @(negedge clk);
      st[1] = 1'b0;
      repeat (4) @(negedge clk);
      clrn = 1'b0;
      #1;
      chk("rst_q",     {16'b0, q16}, 32'd0);
      chk("rst_r",     {16'b0, r16}, 32'd0);
      chk("rst_busy",  {31'b0, busy_v[1]}, 32'd0);
      chk("rst_ready", {31'b0, rdy_v[1]}, 32'd0);
      chk("rst_dbz",   {31'b0, dbz_v[1]}, 32'd0);
      chk("rst_ovf",   {31'b0, ovf_v[1]}, 32'd0);
      sq1.delete();
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (rdy_v[1]) seen++;
      end
      chk("no_ready_after_reset", seen, 0);
      directed("post_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

      run_rand(0, 150);
      run_rand(2, 80);
      run_rand(1, 40);

      repeat (3) @(negedge clk);
      chk("queues_drained", qsize(0) + qsize(1) + qsize(2), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
